// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width: indexes multiplier bits 0..n-1, never narrower than 1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_step.sv
// One multiplier-bit step: conditionally add the multiplicand, shifted by the bit index.
module mult_step
  import seq_mult_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = cnt_width(N)
) (
  input  logic [2*N-1:0] acc_in,
  input  logic [N-1:0]   mcand,
  input  logic           mbit,
  input  logic [CW-1:0]  shift,
  output logic [2*N-1:0] acc_out
);

  logic [2*N-1:0] addend;

  assign addend  = mbit ? ({{N{1'b0}}, mcand} << shift) : '0;
  assign acc_out = acc_in + addend;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential N x N multiplier, one multiplier bit per cycle, valid/ready on both sides.
// Define SEQ_MULT_SIGNED_EN to honour sgn (two's-complement via magnitudes + final negate).
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// BUSY  | N cycles, one multiplier bit per cycle into the accumulator
// DONE  | out_valid=1, p held until out_ready
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_e         state_q;
  logic [N-1:0]   a_q, b_q;
  logic [2*N-1:0] acc_q, acc_next, p_q, p_final;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   a_mag, b_mag;
  logic           accept;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;
  assign accept    = in_valid && in_ready;

`ifdef SEQ_MULT_SIGNED_EN
  logic a_neg, b_neg, neg_q;

  assign a_neg   = sgn & a[N-1];
  assign b_neg   = sgn & b[N-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign p_final = neg_q ? -acc_next : acc_next;

  always_ff @(posedge clk) begin
    if (rst)         neg_q <= 1'b0;
    else if (accept) neg_q <= a_neg ^ b_neg;
  end
`else
  logic unused_sgn;

  assign unused_sgn = sgn;
  assign a_mag      = a;
  assign b_mag      = b;
  assign p_final    = acc_next;
`endif

  mult_step #(.N(N), .CW(CW)) u_step (
    .acc_in  (acc_q),
    .mcand   (a_q),
    .mbit    (b_q[cnt_q]),
    .shift   (cnt_q),
    .acc_out (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a_mag;
            b_q     <= b_mag;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            p_q     <= p_final;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier (N=4): cycle-level expectation model plus directed literal cases.
module tb_seq_multiplier;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           sgn = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*N-1:0] p;

  int errors = 0;
  int checks = 0;

  seq_multiplier #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference product from the arithmetic definition.
  function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] x, input logic [N-1:0] y,
                                              input logic s);
    longint sx, sy, t;
    sx = longint'(x);
    sy = longint'(y);
`ifdef SEQ_MULT_SIGNED_EN
    if (s) begin
      if (x[N-1]) sx = sx - (longint'(1) << N);
      if (y[N-1]) sy = sy - (longint'(1) << N);
    end
`else
    if (s) t = 0;
`endif
    t = sx * sy;
    return t[2*N-1:0];
  endfunction

  // Transaction-level model: an accepted operation is pending for N cycles, then
  // presents its product until out_ready.
  bit             m_pending = 0;
  int             m_since = 0;
  int             m_accepts = 0;
  logic [2*N-1:0] m_prod = '0;
  logic [2*N-1:0] m_phold = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_pending = 0;
      m_phold   = '0;
    end else if (m_pending) begin
      if (m_since >= N) begin
        if (out_ready) m_pending = 0;
      end else begin
        m_since++;
        if (m_since == N) m_phold = m_prod;
      end
    end else if (in_valid) begin
      m_pending = 1;
      m_since   = 0;
      m_prod    = ref_prod(a, b, sgn);
      m_accepts++;
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, !m_pending);
    check("out_valid", out_valid, m_pending && (m_since >= N));
    check("p", p, m_phold);
  end

  task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sv,
                        input logic [2*N-1:0] exp, input int hold);
    int lat;
    @(negedge clk);
    a = av; b = bv; sgn = sv; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      a = N'($urandom); b = N'($urandom); sgn = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, N + 1);
    check("p_literal", p, exp);
    repeat (hold) begin
      in_valid = 1'b1;
      a = N'($urandom); b = N'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_p", p, exp);
      check("hold_no_accept", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("ready_back", in_ready, 1'b1);
    check("valid_drop", out_valid, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    int acc0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_p", p, 0);

    run_op(4'd13, 4'd11, 1'b0, 8'd143, 0);
    run_op(4'd15, 4'd15, 1'b0, 8'd225, 0);
    run_op(4'd0,  4'd9,  1'b0, 8'd0,   0);
    run_op(4'd9,  4'd13, 1'b0, 8'd117, 7);
`ifdef SEQ_MULT_SIGNED_EN
    run_op(4'hD, 4'd5, 1'b1, 8'hF1, 0);
    run_op(4'h8, 4'h8, 1'b1, 8'h40, 0);
`else
    run_op(4'hD, 4'd5, 1'b1, 8'd65, 0);
    run_op(4'h8, 4'h8, 1'b1, 8'd64, 0);
`endif

    // Reset on the second BUSY cycle abandons the operation.
    @(negedge clk);
    a = 4'd7; b = 4'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_p", p, 0);
    run_op(4'd6, 4'd7, 1'b0, 8'd42, 0);

    // Reset wins over a simultaneous accept.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 4'd3; b = 4'd3;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("rst_prio_idle", in_ready, 1'b1);

    // Back-to-back throughput with out_ready held high.
    acc0 = m_accepts;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (3 * (N + 2)) begin
      a = N'($urandom); b = N'($urandom); sgn = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("throughput", m_accepts - acc0, 3);
    repeat (N + 3) @(negedge clk);

    // Random traffic against the model.
    repeat (600) begin
      in_valid  = 1'($urandom);
      a         = N'($urandom);
      b         = N'($urandom);
      sgn       = 1'($urandom);
      out_ready = ($urandom_range(3) != 0);
      rst       = ($urandom_range(63) == 0);
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (N + 3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
